// File: rtl/round_sequencer_pkg.sv
// round_sequencer_pkg: state codes, limits and helpers shared by the
// round sequencer and the bar/ball datapath.
package round_sequencer_pkg;

  localparam logic [3:0] ST_PLAY      = 4'd0;
  localparam logic [3:0] ST_GAMEOVER  = 4'd1;
  localparam logic [3:0] ST_IDLE      = 4'd2;
  localparam logic [3:0] ST_COUNTDOWN = 4'd3;
  localparam logic [3:0] ST_PAUSE     = 4'd4;

  localparam logic [9:0] SEC_MAX   = 10'd999;
  localparam logic [1:0] LEVEL_MAX = 2'd3;

  // Thermometer step: enable one more ball.
  function automatic logic [3:0] next_ball(input logic [3:0] be);
    return {be[2:0], 1'b1};
  endfunction

endpackage

// File: rtl/round_sequencer_key_press_detector.sv
// key_press_detector: 2-FF synchroniser plus falling-edge pulse for an
// active-low key. Ports: CLOCK_50, reset (async, active-low), key_n, press.
module key_press_detector (
  input  logic CLOCK_50,
  input  logic reset,
  input  logic key_n,
  output logic press
);

  logic s1;
  logic s2;
  logic s3;

  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= key_n;
      s2 <= s1;
      s3 <= s2;
    end
  end

  // One pulse per 1->0 edge of the synchronised key.
  assign press = s3 & ~s2;

endmodule

// File: rtl/round_sequencer.sv
// round_sequencer: IDLE -> COUNTDOWN -> PLAY -> GAMEOVER round FSM with
// one-second prescaler, level timer and progressive ball release.
// Ports: CLOCK_50, reset (async, active-low), keyStart, keyPause,
// gameover_flags[3:0] in; game_state[3:0], ball_enable[3:0], round_start,
// level[1:0], countdown[1:0], play_seconds[9:0] out (all registered).
// Optional pause support is built when PAUSE_ROUND_EN is defined.
module round_sequencer
  import round_sequencer_pkg::*;
#(
  parameter int TICKS_PER_SEC = 50_000_000,
  parameter int COUNTDOWN_SEC = 3,
  parameter int LEVEL_SEC     = 20
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic       keyStart,
  input  logic       keyPause,
  input  logic [3:0] gameover_flags,
  output logic [3:0] game_state,
  output logic [3:0] ball_enable,
  output logic       round_start,
  output logic [1:0] level,
  output logic [1:0] countdown,
  output logic [9:0] play_seconds
);

  localparam int SW = $clog2(TICKS_PER_SEC + 1);
  localparam int LW = $clog2(LEVEL_SEC + 1);
  localparam logic [SW-1:0] SEC_LAST = SW'(TICKS_PER_SEC - 1);
  localparam logic [LW-1:0] LVL_LAST = LW'(LEVEL_SEC - 1);
  localparam logic [1:0]    CD_INIT  = 2'(COUNTDOWN_SEC);

  logic start_press;
  logic pause_press;

  key_press_detector u_start (
    .CLOCK_50 (CLOCK_50),
    .reset    (reset),
    .key_n    (keyStart),
    .press    (start_press)
  );

`ifdef PAUSE_ROUND_EN
  key_press_detector u_pause (
    .CLOCK_50 (CLOCK_50),
    .reset    (reset),
    .key_n    (keyPause),
    .press    (pause_press)
  );
`else
  logic unused_pause;
  assign unused_pause = keyPause;
  assign pause_press  = 1'b0;
`endif

  logic [SW-1:0] sec_cnt;
  logic [SW-1:0] sec_next;
  logic [LW-1:0] lvl_cnt;
  logic          sec_tick;
  logic          hit;

  assign sec_tick = (sec_cnt == SEC_LAST);
  assign sec_next = sec_tick ? '0 : sec_cnt + SW'(1);
  // Only misses from balls in play end the round.
  assign hit      = |(gameover_flags & ball_enable);

  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      game_state   <= ST_IDLE;
      ball_enable  <= '0;
      round_start  <= 1'b0;
      level        <= '0;
      countdown    <= '0;
      play_seconds <= '0;
      sec_cnt      <= '0;
      lvl_cnt      <= '0;
    end else begin
      round_start <= 1'b0;
      case (game_state)
        ST_IDLE, ST_GAMEOVER: begin
          if (start_press) begin
            game_state <= ST_COUNTDOWN;
            countdown  <= CD_INIT;
            sec_cnt    <= '0;
          end
        end
        ST_COUNTDOWN: begin
          sec_cnt <= sec_next;
          if (sec_tick) begin
            if (countdown == 2'd1) begin
              game_state   <= ST_PLAY;
              countdown    <= '0;
              level        <= '0;
              ball_enable  <= 4'b0001;
              play_seconds <= '0;
              lvl_cnt      <= '0;
              sec_cnt      <= '0;
              round_start  <= 1'b1;
            end else begin
              countdown <= countdown - 2'd1;
            end
          end
        end
        ST_PLAY: begin
          // Miss beats pause, pause beats the tick.
          if (hit) begin
            game_state <= ST_GAMEOVER;
          end else if (pause_press) begin
            game_state <= ST_PAUSE;
          end else begin
            sec_cnt <= sec_next;
            if (sec_tick) begin
              if (play_seconds != SEC_MAX)
                play_seconds <= play_seconds + 10'd1;
              if (lvl_cnt == LVL_LAST) begin
                lvl_cnt <= '0;
                if (level != LEVEL_MAX) begin
                  level       <= level + 2'd1;
                  ball_enable <= next_ball(ball_enable);
                end
              end else begin
                lvl_cnt <= lvl_cnt + LW'(1);
              end
            end
          end
        end
`ifdef PAUSE_ROUND_EN
        ST_PAUSE: begin
          if (pause_press)
            game_state <= ST_PLAY;
        end
`endif
        default: game_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_round_sequencer.sv
// tb_round_sequencer: directed + randomized bench for round_sequencer with
// a second-count based reference model and a per-cycle compare process.
module tb_round_sequencer;

  localparam int T = 4;
  localparam int C = 3;
  localparam int L = 2;
`ifdef PAUSE_ROUND_EN
  localparam bit PAUSE_EN = 1'b1;
`else
  localparam bit PAUSE_EN = 1'b0;
`endif

  logic       CLOCK_50 = 1'b0;
  logic       reset;
  logic       keyStart;
  logic       keyPause;
  logic [3:0] gameover_flags;
  logic [3:0] game_state;
  logic [3:0] ball_enable;
  logic       round_start;
  logic [1:0] level;
  logic [1:0] countdown;
  logic [9:0] play_seconds;

  round_sequencer #(
    .TICKS_PER_SEC (T),
    .COUNTDOWN_SEC (C),
    .LEVEL_SEC     (L)
  ) dut (
    .CLOCK_50       (CLOCK_50),
    .reset          (reset),
    .keyStart       (keyStart),
    .keyPause       (keyPause),
    .gameover_flags (gameover_flags),
    .game_state     (game_state),
    .ball_enable    (ball_enable),
    .round_start    (round_start),
    .level          (level),
    .countdown      (countdown),
    .play_seconds   (play_seconds)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  int checks   = 0;
  int failures = 0;
  bit chk_en   = 0;

  // Reference model: state code, cycles spent in countdown, active PLAY
  // cycles this round; displayed values are derived by division.
  int ms;
  int cd_cyc;
  int act;
  bit has_round;
  bit rs;
  bit kh [3];
  bit ph [3];

  function automatic int m_level();
    int v;
    if (!has_round) return 0;
    v = act / (T * L);
    return (v > 3) ? 3 : v;
  endfunction

  function automatic int m_balls();
    if (!has_round) return 0;
    return (1 << (m_level() + 1)) - 1;
  endfunction

  function automatic int m_secs();
    int v;
    if (!has_round) return 0;
    v = act / T;
    return (v > 999) ? 999 : v;
  endfunction

  function automatic int m_cd();
    return (ms == 3) ? C - cd_cyc / T : 0;
  endfunction

  always @(posedge CLOCK_50 or negedge reset) begin
    bit sp;
    bit pp;
    if (!reset) begin
      ms = 2; cd_cyc = 0; act = 0; has_round = 0; rs = 0;
      for (int i = 0; i < 3; i++) begin kh[i] = 0; ph[i] = 0; end
    end else begin
      sp = kh[2] && !kh[1];
      pp = ph[2] && !ph[1] && PAUSE_EN;
      rs = 0;
      case (ms)
        1, 2: if (sp) begin ms = 3; cd_cyc = 0; end
        3: begin
          cd_cyc++;
          if (cd_cyc == C * T) begin
            ms = 0; act = 0; has_round = 1; rs = 1;
          end
        end
        0: begin
          if ((int'(gameover_flags) & m_balls()) != 0) ms = 1;
          else if (pp) ms = 4;
          else act++;
        end
        4: if (pp) ms = 0;
        default: ms = 2;
      endcase
      kh[2] = kh[1]; kh[1] = kh[0]; kh[0] = keyStart;
      ph[2] = ph[1]; ph[1] = ph[0]; ph[0] = keyPause;
    end
  end

  always @(negedge CLOCK_50) begin
    if (chk_en && reset) begin
      checks++;
      if (int'(game_state) != ms || int'(ball_enable) != m_balls() ||
          int'(round_start) != int'(rs) || int'(level) != m_level() ||
          int'(countdown) != m_cd() || int'(play_seconds) != m_secs()) begin
        failures++;
        $display("FAIL model t=%0t st=%0d/%0d be=%0d/%0d rs=%0d/%0d lv=%0d/%0d cd=%0d/%0d ps=%0d/%0d",
          $time, game_state, ms, ball_enable, m_balls(), round_start, rs,
          level, m_level(), countdown, m_cd(), play_seconds, m_secs());
      end
    end
  end

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", name, got, exp);
    end
  endtask

  task automatic wait_state(input int s, input int bound, output int n);
    n = 0;
    while (int'(game_state) != s && n < bound) begin
      @(negedge CLOCK_50);
      n++;
    end
    if (int'(game_state) != s) begin
      checks++;
      failures++;
      $display("FAIL wait_state got=%0d exp=%0d", game_state, s);
    end
  endtask

  task automatic chk_reset_vals(input string name);
    chk({name, "_st"}, int'(game_state), 2);
    chk({name, "_be"}, int'(ball_enable), 0);
    chk({name, "_rs"}, int'(round_start), 0);
    chk({name, "_lv"}, int'(level), 0);
    chk({name, "_cd"}, int'(countdown), 0);
    chk({name, "_ps"}, int'(play_seconds), 0);
  endtask

  // Press start from IDLE/GAMEOVER and run to the first PLAY cycle.
  task automatic start_round();
    int n;
    keyStart = 1'b0;
    wait_state(3, 10, n);
    keyStart = 1'b1;
    wait_state(0, 20, n);
  endtask

  task automatic force_gameover();
    gameover_flags = 4'b0001;
    @(negedge CLOCK_50);
    gameover_flags = 4'b0000;
  endtask

  initial begin
    int n;
    int entries;
    int prev;
    int ks_hold;
    int kp_hold;
    reset = 1'b0;
    keyStart = 1'b1;
    keyPause = 1'b1;
    gameover_flags = 4'b0000;
    repeat (3) @(negedge CLOCK_50);
    chk_reset_vals("reset");
    reset = 1'b1;
    chk_en = 1;
    repeat (5) @(negedge CLOCK_50);

    // Start, countdown length and round_start.
    keyStart = 1'b0;
    wait_state(3, 10, n);
    chk("start_latency", n, 3);
    chk("cd_init", int'(countdown), 3);
    keyStart = 1'b1;
    wait_state(0, 20, n);
    chk("cd_length", n, 12);
    chk("round_start", int'(round_start), 1);
    chk("first_balls", int'(ball_enable), 1);

    // Ball release every 2 s.
    repeat (8) @(negedge CLOCK_50);
    chk("be_2s", int'(ball_enable), 4'b0011);
    repeat (8) @(negedge CLOCK_50);
    chk("be_4s", int'(ball_enable), 4'b0111);
    repeat (8) @(negedge CLOCK_50);
    chk("be_6s", int'(ball_enable), 4'b1111);
    repeat (8) @(negedge CLOCK_50);
    chk("lv_8s", int'(level), 3);
    chk("ps_8s", int'(play_seconds), 8);

    // Disabled-ball flags ignored; enabled flag ends round; frozen.
    force_gameover();
    chk("go_state", int'(game_state), 1);
    start_round();
    repeat (9) @(negedge CLOCK_50);
    gameover_flags = 4'b0100;
    repeat (3) @(negedge CLOCK_50);
    chk("dis_flag", int'(game_state), 0);
    force_gameover();
    repeat (10) @(negedge CLOCK_50);
    chk("frz_st", int'(game_state), 1);
    chk("frz_be", int'(ball_enable), 4'b0011);
    chk("frz_lv", int'(level), 1);
    chk("frz_ps", int'(play_seconds), 3);

    // Level tick and miss in the same cycle.
    start_round();
    repeat (7) @(negedge CLOCK_50);
    force_gameover();
    chk("tie_st", int'(game_state), 1);
    chk("tie_lv", int'(level), 0);
    chk("tie_be", int'(ball_enable), 1);

    // Held start key gives one transition.
    keyStart = 1'b0;
    entries = 0;
    prev = int'(game_state);
    repeat (100) begin
      @(negedge CLOCK_50);
      if (int'(game_state) == 3 && prev != 3) entries++;
      prev = int'(game_state);
    end
    keyStart = 1'b1;
    chk("held_key", entries, 1);

    // Async reset mid-PLAY and mid-COUNTDOWN.
    repeat (3) @(negedge CLOCK_50);
    #2 reset = 1'b0;
    #1 chk_reset_vals("rst_play");
    @(negedge CLOCK_50);
    #2 reset = 1'b1;
    repeat (5) @(negedge CLOCK_50);
    keyStart = 1'b0;
    wait_state(3, 10, n);
    keyStart = 1'b1;
    repeat (5) @(negedge CLOCK_50);
    #2 reset = 1'b0;
    #1 chk_reset_vals("rst_cd");
    @(negedge CLOCK_50);
    #2 reset = 1'b1;
    repeat (5) @(negedge CLOCK_50);

    // Pause.
    start_round();
    repeat (10) @(negedge CLOCK_50);
    keyPause = 1'b0;
`ifdef PAUSE_ROUND_EN
    wait_state(4, 10, n);
    chk("pause_lat", n, 3);
    keyPause = 1'b1;
    repeat (40) @(negedge CLOCK_50);
    chk("pause_st", int'(game_state), 4);
    chk("pause_ps", int'(play_seconds), 3);
    keyPause = 1'b0;
    wait_state(0, 10, n);
    keyPause = 1'b1;
    n = 0;
    while (level != 2'd2 && n < 20) begin
      @(negedge CLOCK_50);
      n++;
    end
    chk("resume_lvl", n, 4);
`else
    repeat (20) @(negedge CLOCK_50);
    keyPause = 1'b1;
    chk("pause_off_st", int'(game_state), 0);
    chk("pause_off_ps", int'(play_seconds), 7);
`endif

    // Saturation of the seconds counter.
    force_gameover();
    start_round();
    repeat (4000) @(negedge CLOCK_50);
    chk("sat_ps", int'(play_seconds), 999);
    chk("sat_lv", int'(level), 3);

    // Random stimulus against the model.
    force_gameover();
    ks_hold = 0;
    kp_hold = 0;
    for (int i = 0; i < 4000; i++) begin
      @(negedge CLOCK_50);
      gameover_flags = ($urandom_range(0, 39) == 0) ?
                       4'($urandom_range(1, 15)) : 4'd0;
      if (ks_hold > 0) begin
        ks_hold--;
        if (ks_hold == 0) keyStart = 1'b1;
      end else if ($urandom_range(0, 29) == 0) begin
        keyStart = 1'b0;
        ks_hold = $urandom_range(1, 6);
      end
      if (kp_hold > 0) begin
        kp_hold--;
        if (kp_hold == 0) keyPause = 1'b1;
      end else if ($urandom_range(0, 19) == 0) begin
        keyPause = 1'b0;
        kp_hold = $urandom_range(1, 6);
      end
    end
    keyStart = 1'b1;
    keyPause = 1'b1;
    gameover_flags = 4'b0000;
    repeat (5) @(negedge CLOCK_50);

    chk_en = 0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
